// File: rtl/obstacle_spawner.sv
// Obstacle spawner: turns the LFSR byte into timed spawn requests.
// Ports: clk_in/rst_in, game_active_in, tick_in, level_in, rand_in, spawn_ready_in,
//        spawn_valid_out, spawn_type_out, spawn_count_out, gap_cnt_out.
module obstacle_spawner #(
  parameter int MIN_GAP   = 24,
  parameter int MIN_FLOOR = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        game_active_in,
  input  logic        tick_in,
  input  logic [3:0]  level_in,
  input  logic [7:0]  rand_in,
  input  logic        spawn_ready_in,
  output logic        spawn_valid_out,
  output logic [1:0]  spawn_type_out,
  output logic [15:0] spawn_count_out,
  output logic [7:0]  gap_cnt_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    OFFER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [1:0]  type_q, type_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;

  logic signed [9:0] eff_min_raw;
  logic signed [9:0] eff_min;
  logic [7:0]        gap;

  // Level shortens the minimum gap by two ticks per level, floored.
  always_comb begin
    eff_min_raw = 10'(MIN_GAP) - $signed({5'b0, level_in, 1'b0});
    if (eff_min_raw < $signed(10'(MIN_FLOOR))) begin
      eff_min = 10'(MIN_FLOOR);
    end else begin
      eff_min = eff_min_raw;
    end
    gap = eff_min[7:0] + {3'b0, rand_in[7:3]};
  end

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    count_d   = count_q;
    gap_cnt_d = gap_cnt_q;
    if (!game_active_in) begin
      // Abort wins over any handshake; count and type hold.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          gap_cnt_d = gap;
          count_d   = '0;
          state_d   = WAIT;
        end
        WAIT: begin
          if (tick_in) begin
            if (gap_cnt_q != 8'd0) begin
              gap_cnt_d = gap_cnt_q - 8'd1;
            end else begin
              type_d  = rand_in[1:0];
              state_d = OFFER;
            end
          end
        end
        OFFER: begin
          if (spawn_ready_in) begin
            if (count_q != 16'hFFFF) begin
              count_d = count_q + 16'd1;
            end
            gap_cnt_d = gap;
            state_d   = WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Registered valid tracks the state being entered.
    valid_d = (state_d == OFFER);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      type_q    <= 2'd0;
      count_q   <= 16'd0;
      gap_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      type_q    <= type_d;
      count_q   <= count_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign spawn_valid_out = valid_q;
  assign spawn_type_out  = type_q;
  assign spawn_count_out = count_q;
  assign gap_cnt_out     = gap_cnt_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner.
// Linear stimulus, immediate assertions at each check.
module tb_obstacle_spawner;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        game_active_in = 1'b0;
  logic        tick_in = 1'b0;
  logic [3:0]  level_in = 4'd0;
  logic [7:0]  rand_in = 8'd0;
  logic        spawn_ready_in = 1'b0;
  logic        spawn_valid_out;
  logic [1:0]  spawn_type_out;
  logic [15:0] spawn_count_out;
  logic [7:0]  gap_cnt_out;

  int checks = 0;
  int failures = 0;

  obstacle_spawner dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .game_active_in  (game_active_in),
    .tick_in         (tick_in),
    .level_in        (level_in),
    .rand_in         (rand_in),
    .spawn_ready_in  (spawn_ready_in),
    .spawn_valid_out (spawn_valid_out),
    .spawn_type_out  (spawn_type_out),
    .spawn_count_out (spawn_count_out),
    .gap_cnt_out     (gap_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_in = 1'b1;
      step();
      tick_in = 1'b0;
      step();
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(spawn_valid_out), 32'd0);
    check({tag, "_type"},  32'(spawn_type_out),  32'd0);
    check({tag, "_count"}, 32'(spawn_count_out), 32'd0);
    check({tag, "_gap"},   32'(gap_cnt_out),     32'd0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check_all_zero("reset");
    rst_in = 1'b0;
    step();
    check("idle_valid", 32'(spawn_valid_out), 32'd0);

    // 1: level 0, rand 0 -> gap 24, OFFER after 25th tick
    spawn_ready_in = 1'b1;
    game_active_in = 1'b1;
    step();
    check("t1_load_gap", 32'(gap_cnt_out), 32'd24);
    check("t1_load_cnt", 32'(spawn_count_out), 32'd0);
    ticks(24);
    check("t1_gap0", 32'(gap_cnt_out), 32'd0);
    check("t1_not_yet", 32'(spawn_valid_out), 32'd0);
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    check("t1_valid", 32'(spawn_valid_out), 32'd1);
    check("t1_type", 32'(spawn_type_out), 32'd0);
    check("t1_cnt_pre", 32'(spawn_count_out), 32'd0);
    step();
    check("t1_cnt_acc", 32'(spawn_count_out), 32'd1);
    check("t1_valid_drop", 32'(spawn_valid_out), 32'd0);
    check("t1_reload", 32'(gap_cnt_out), 32'd24);

    // 2: rand 0xFB -> gap 55, type 3; tick in load cycle ignored
    game_active_in = 1'b0;
    step();
    check("t2_abort_cnt_hold", 32'(spawn_count_out), 32'd1);
    spawn_ready_in = 1'b0;
    rand_in = 8'hFB;
    tick_in = 1'b1;
    game_active_in = 1'b1;
    step();
    tick_in = 1'b0;
    check("t2_load_gap", 32'(gap_cnt_out), 32'd55);
    check("t2_cnt_clr", 32'(spawn_count_out), 32'd0);
    ticks(55);
    check("t2_gap0", 32'(gap_cnt_out), 32'd0);
    check("t2_not_yet", 32'(spawn_valid_out), 32'd0);
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    check("t2_valid", 32'(spawn_valid_out), 32'd1);
    check("t2_type", 32'(spawn_type_out), 32'd3);

    // 4: stall 20 cycles with 5 ticks and changing rand
    repeat (5) begin
      tick_in = 1'b1;
      rand_in = 8'($urandom);
      step();
      tick_in = 1'b0;
      repeat (3) step();
    end
    check("t4_valid_hold", 32'(spawn_valid_out), 32'd1);
    check("t4_type_hold", 32'(spawn_type_out), 32'd3);
    check("t4_gap_hold", 32'(gap_cnt_out), 32'd0);
    check("t4_cnt_hold", 32'(spawn_count_out), 32'd0);
    rand_in = 8'h00;
    level_in = 4'd7;
    spawn_ready_in = 1'b1;
    step();
    spawn_ready_in = 1'b0;
    check("t4_cnt_acc", 32'(spawn_count_out), 32'd1);
    check("t4_gap_l7", 32'(gap_cnt_out), 32'd10);
    check("t4_valid_drop", 32'(spawn_valid_out), 32'd0);

    // 3: level floors and extremes
    game_active_in = 1'b0;
    step();
    level_in = 4'd12;
    game_active_in = 1'b1;
    step();
    check("t3_gap_l12", 32'(gap_cnt_out), 32'd8);
    game_active_in = 1'b0;
    step();
    level_in = 4'd15;
    rand_in = 8'hF8;
    game_active_in = 1'b1;
    step();
    check("t3_gap_l15", 32'(gap_cnt_out), 32'd39);
    game_active_in = 1'b0;
    step();
    level_in = 4'd3;
    rand_in = 8'h08;
    game_active_in = 1'b1;
    step();
    check("t3_gap_l3", 32'(gap_cnt_out), 32'd19);

    // 5: abort coincident with ready in OFFER
    game_active_in = 1'b0;
    step();
    level_in = 4'd12;
    rand_in = 8'h00;
    game_active_in = 1'b1;
    step();
    check("t5_gap", 32'(gap_cnt_out), 32'd8);
    ticks(8);
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    check("t5_valid_a", 32'(spawn_valid_out), 32'd1);
    spawn_ready_in = 1'b1;
    step();
    spawn_ready_in = 1'b0;
    check("t5_cnt1", 32'(spawn_count_out), 32'd1);
    ticks(8);
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    check("t5_valid_b", 32'(spawn_valid_out), 32'd1);
    spawn_ready_in = 1'b1;
    game_active_in = 1'b0;
    step();
    spawn_ready_in = 1'b0;
    check("t5_abort_valid", 32'(spawn_valid_out), 32'd0);
    check("t5_abort_cnt", 32'(spawn_count_out), 32'd1);
    game_active_in = 1'b1;
    step();
    check("t5_re_cnt", 32'(spawn_count_out), 32'd0);
    check("t5_re_gap", 32'(gap_cnt_out), 32'd8);

    // 6: saturation, then async reset
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    check("t6_forced", 32'(spawn_count_out), 32'hFFFF);
    ticks(8);
    rand_in = 8'h03;
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    check("t6_valid", 32'(spawn_valid_out), 32'd1);
    check("t6_type", 32'(spawn_type_out), 32'd3);
    spawn_ready_in = 1'b1;
    step();
    spawn_ready_in = 1'b0;
    check("t6_sat", 32'(spawn_count_out), 32'hFFFF);
    check("t6_gap", 32'(gap_cnt_out), 32'd8);
    ticks(8);
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    check("t6_offer2", 32'(spawn_valid_out), 32'd1);
    #2;
    rst_in = 1'b1;
    #1;
    check_all_zero("t6_rst_offer");
    step();
    rst_in = 1'b0;
    level_in = 4'd0;
    rand_in = 8'h00;
    step();
    check("t6_reload", 32'(gap_cnt_out), 32'd24);
    ticks(3);
    check("t6_wait_gap", 32'(gap_cnt_out), 32'd21);
    #2;
    rst_in = 1'b1;
    #1;
    check_all_zero("t6_rst_wait");
    step();
    rst_in = 1'b0;
    game_active_in = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
